// File: rtl/pc_pkg.sv
// Shared types and helpers for the program-counter unit.
package pc_pkg;

  typedef enum logic [2:0] {
    SRC_SEQ,
    SRC_BR,
    SRC_J,
    SRC_JR,
    SRC_RAS,
    SRC_ERET,
    SRC_EXC
  } pc_src_e;

  localparam int unsigned JIDX_W = 26;
  localparam int unsigned IMM_W  = 32;

  // Sequential increment for the chosen fetch addressing.
  function automatic int unsigned pc_inc(input bit byte_addr);
    return byte_addr ? 4 : 1;
  endfunction

  // Left shift turning an instruction count into an address offset.
  function automatic int unsigned pc_shift(input bit byte_addr);
    return byte_addr ? 2 : 0;
  endfunction

endpackage

// File: rtl/pc_ras.sv
// Return-address stack: circular buffer that overwrites its oldest entry when full.
module pc_ras
  import pc_pkg::*;
#(
  parameter int unsigned RAS_DEPTH = 4,
  parameter int unsigned ADDR_W    = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              push,
  input  logic              pop,
  input  logic [ADDR_W-1:0] push_data,
  output logic [ADDR_W-1:0] top,
  output logic              empty,
  output logic              ovf
);

  localparam int unsigned PTR_W = $clog2(RAS_DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] FULL = CNT_W'(RAS_DEPTH);

  logic [ADDR_W-1:0] mem [RAS_DEPTH];
  logic [PTR_W-1:0]  ptr;
  logic [PTR_W-1:0]  ptr_inc;
  logic [CNT_W-1:0]  cnt;
  logic              do_pop;

  assign empty   = (cnt == '0);
  assign top     = mem[ptr];
  assign ptr_inc = ptr + 1'b1;
  assign do_pop  = pop & ~empty;

  // Pop-then-push collapses to replacing the top entry in place.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ptr <= '0;
      cnt <= '0;
      ovf <= 1'b0;
      for (int unsigned i = 0; i < RAS_DEPTH; i++) mem[PTR_W'(i)] <= '0;
    end else if (do_pop && push) begin
      mem[ptr] <= push_data;
    end else if (do_pop) begin
      ptr <= ptr - 1'b1;
      cnt <= cnt - 1'b1;
    end else if (push) begin
      ptr          <= ptr_inc;
      mem[ptr_inc] <= push_data;
      if (cnt == FULL) ovf <= 1'b1;
      else             cnt <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/pc_unit.sv
// Program counter with branch/jump/jr targets, return-address stack and exception vectoring.
module pc_unit
  import pc_pkg::*;
#(
  parameter int unsigned       ADDR_W    = 32,
  parameter bit                BYTE_ADDR = 1'b1,
  parameter logic [ADDR_W-1:0] RESET_VEC = '0,
  parameter logic [ADDR_W-1:0] EXC_VEC   = ADDR_W'(32'h80),
  parameter int unsigned       RAS_DEPTH = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              stall,
  input  logic              branch,
  input  logic              branch_ne,
  input  logic              zero_flag,
  input  logic [IMM_W-1:0]  imm_ext,
  input  logic              jump,
  input  logic [JIDX_W-1:0] jump_idx,
  input  logic              jr,
  input  logic [ADDR_W-1:0] jr_target,
  input  logic              call,
  input  logic              ret,
  input  logic              exception,
  input  logic              eret,
  output logic [ADDR_W-1:0] pc,
  output logic [ADDR_W-1:0] pc_nxt,
  output logic [ADDR_W-1:0] epc,
  output logic              ras_miss,
  output logic              ras_ovf,
  output logic              misaligned
);

  localparam int unsigned       INC     = pc_inc(BYTE_ADDR);
  localparam int unsigned       SH      = pc_shift(BYTE_ADDR);
  localparam logic [ADDR_W-1:0] LO_MASK = ~({ADDR_W{1'b1}} << SH);
  localparam logic [ADDR_W-1:0] HI_MASK = {ADDR_W{1'b1}} << (JIDX_W + SH);

  logic [ADDR_W-1:0] seq;
  logic [ADDR_W-1:0] imm_w;
  logic [ADDR_W-1:0] br_tgt;
  logic [ADDR_W-1:0] j_tgt;
  logic [ADDR_W-1:0] jr_tgt;
  logic [ADDR_W-1:0] ras_top;
  logic              ras_empty;
  logic              br_taken;
  logic              ras_push;
  logic              ras_pop;
  pc_src_e           src;

  assign seq        = pc + ADDR_W'(INC);
  assign imm_w      = ADDR_W'($signed(imm_ext));
  assign br_tgt     = seq + (imm_w << SH);
  assign j_tgt      = (seq & HI_MASK) | (ADDR_W'(jump_idx) << SH);
  assign jr_tgt     = jr_target & ~LO_MASK;
  assign misaligned = |(jr_target & LO_MASK);
  assign br_taken   = branch & (zero_flag ^ branch_ne);

  // Redirect source, highest priority first.
  always_comb begin
    src = SRC_SEQ;
    if (exception)     src = SRC_EXC;
    else if (eret)     src = SRC_ERET;
    else if (ret)      src = SRC_RAS;
    else if (jr)       src = SRC_JR;
    else if (jump)     src = SRC_J;
    else if (br_taken) src = SRC_BR;
  end

  // Stall freezes the PC unless a trap forces the vector.
  always_comb begin
    pc_nxt   = seq;
    ras_miss = 1'b0;
    if (stall && !exception) begin
      pc_nxt = pc;
    end else begin
      case (src)
        SRC_EXC:  pc_nxt = EXC_VEC;
        SRC_ERET: pc_nxt = epc;
        SRC_RAS: begin
          ras_miss = ras_empty;
          pc_nxt   = ras_empty ? jr_tgt : ras_top;
        end
        SRC_JR:   pc_nxt = jr_tgt;
        SRC_J:    pc_nxt = j_tgt;
        SRC_BR:   pc_nxt = br_tgt;
        default:  pc_nxt = seq;
      endcase
    end
  end

  // Stack traffic only for a taken call/return; traps and stalls leave it untouched.
  assign ras_pop  = ~stall & (src == SRC_RAS);
  assign ras_push = ~stall & call & (jump | jr) &
                    ((src == SRC_J) | (src == SRC_JR) | (src == SRC_RAS));

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pc  <= RESET_VEC;
      epc <= '0;
    end else begin
      pc <= pc_nxt;
      if (exception) epc <= pc;
    end
  end

  pc_ras #(
    .RAS_DEPTH (RAS_DEPTH),
    .ADDR_W    (ADDR_W)
  ) u_ras (
    .clk       (clk),
    .reset     (reset),
    .push      (ras_push),
    .pop       (ras_pop),
    .push_data (seq),
    .top       (ras_top),
    .empty     (ras_empty),
    .ovf       (ras_ovf)
  );

endmodule

// File: tb/tb_pc_unit.sv
// Scoreboard bench for pc_unit: byte-addressed main instance plus a word-addressed instance.
module tb_pc_unit;

  localparam int unsigned AW = 32;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  logic          stall, branch, branch_ne, zero_flag, jump, jr, call, ret, exception, eret;
  logic [31:0]   imm_ext;
  logic [25:0]   jump_idx;
  logic [AW-1:0] jr_target;
  logic [AW-1:0] pc, pc_nxt, epc;
  logic          ras_miss, ras_ovf, misaligned;

  logic          w_jump;
  logic [25:0]   w_idx;
  logic [AW-1:0] w_pc, w_pc_nxt, w_epc;
  logic          w_miss, w_ovf, w_mis;

  pc_unit #(
    .ADDR_W(32), .BYTE_ADDR(1'b1), .RESET_VEC(32'h0), .EXC_VEC(32'h80), .RAS_DEPTH(4)
  ) u_dut (
    .clk(clk), .reset(reset), .stall(stall), .branch(branch), .branch_ne(branch_ne),
    .zero_flag(zero_flag), .imm_ext(imm_ext), .jump(jump), .jump_idx(jump_idx), .jr(jr),
    .jr_target(jr_target), .call(call), .ret(ret), .exception(exception), .eret(eret),
    .pc(pc), .pc_nxt(pc_nxt), .epc(epc), .ras_miss(ras_miss), .ras_ovf(ras_ovf),
    .misaligned(misaligned)
  );

  pc_unit #(
    .ADDR_W(32), .BYTE_ADDR(1'b0), .RESET_VEC(32'h0), .EXC_VEC(32'h80), .RAS_DEPTH(4)
  ) u_word (
    .clk(clk), .reset(reset), .stall(1'b0), .branch(1'b0), .branch_ne(1'b0),
    .zero_flag(1'b0), .imm_ext(32'h0), .jump(w_jump), .jump_idx(w_idx), .jr(1'b0),
    .jr_target(32'h0), .call(1'b0), .ret(1'b0), .exception(1'b0), .eret(1'b0),
    .pc(w_pc), .pc_nxt(w_pc_nxt), .epc(w_epc), .ras_miss(w_miss), .ras_ovf(w_ovf),
    .misaligned(w_mis)
  );

  typedef struct {
    string         tag;
    logic [AW-1:0] pc;
  } exp_t;

  exp_t exp_q[$];
  int   n_vec = 0;
  int   n_err = 0;

  task automatic chk(input string tag, input logic [AW-1:0] obs, input logic [AW-1:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Each driven cycle queues one expected pc, checked just after the edge.
  always @(posedge clk) begin
    exp_t e;
    #1;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      chk(e.tag, pc, e.pc);
    end
  end

  task automatic clear_inputs();
    stall = 0; branch = 0; branch_ne = 0; zero_flag = 0; jump = 0; jr = 0;
    call = 0; ret = 0; exception = 0; eret = 0;
    imm_ext = '0; jump_idx = '0; jr_target = '0;
  endtask

  task automatic step(input string tag, input logic [AW-1:0] exp_pc);
    exp_t e;
    e.tag = tag;
    e.pc  = exp_pc;
    exp_q.push_back(e);
    @(negedge clk);
    clear_inputs();
  endtask

  task automatic goto(input logic [AW-1:0] a);
    jr = 1; jr_target = a;
    step("goto", a);
  endtask

  logic [AW-1:0] ra [5];
  logic [AW-1:0] cur, tgt;
  logic [25:0]   idx;

  initial begin
    clear_inputs();
    w_jump = 0; w_idx = '0;
    #2 reset = 0;
    @(negedge clk);
    @(negedge clk);
    chk("rst_pc", pc, 32'h0);
    chk("rst_epc", epc, 32'h0);
    chk("rst_ovf", 32'(ras_ovf), 32'h0);
    chk("rst_pc_nxt", pc_nxt, 32'h4);
    chk("w_rst_pc", w_pc, 32'h0);
    reset = 1;

    // Free run; word instance takes a jump on the first edge.
    w_jump = 1; w_idx = 26'h10;
    step("free1", 32'h4);
    w_jump = 0;
    chk("w_jump", w_pc, 32'h10);
    step("free2", 32'h8);
    chk("w_seq", w_pc, 32'h11);
    chk("w_pc_nxt", w_pc_nxt, 32'h12);
    chk("w_flags", {w_epc[29:0], w_miss, w_ovf | w_mis}, 32'h0);
    step("free3", 32'hC);

    // Conditional branches from 0x100 with offset -2 instructions.
    goto(32'h100);
    branch = 1; zero_flag = 1; imm_ext = -32'sd2;
    step("beq_taken", 32'hFC);
    goto(32'h100);
    branch = 1; zero_flag = 0; imm_ext = -32'sd2;
    step("beq_not", 32'h104);
    goto(32'h100);
    branch = 1; branch_ne = 1; zero_flag = 0; imm_ext = -32'sd2;
    step("bne_taken", 32'hFC);

    // Call and return, then return on an empty stack.
    goto(32'h20);
    jump = 1; call = 1; jump_idx = 26'h40;
    step("jal", 32'h100);
    ret = 1;
    #1 chk("ret_hit_miss", 32'(ras_miss), 32'h0);
    step("ret_hit", 32'h24);
    ret = 1; jr_target = 32'h300;
    #1 chk("ret_empty_miss", 32'(ras_miss), 32'h1);
    step("ret_empty", 32'h300);

    // Five nested calls on a four-deep stack.
    cur = 32'h300;
    for (int i = 0; i < 5; i++) begin
      ra[i] = cur + 32'h4;
      idx   = 26'(32'h100 + 32'(i) * 32'h40);
      tgt   = 32'h400 + 32'(i) * 32'h100;
      jump = 1; call = 1; jump_idx = idx;
      step($sformatf("call%0d", i), tgt);
      cur = tgt;
      if (i == 3) chk("ovf_at_depth", 32'(ras_ovf), 32'h0);
    end
    chk("ovf_set", 32'(ras_ovf), 32'h1);
    for (int i = 4; i >= 1; i--) begin
      ret = 1;
      #1 chk($sformatf("ret%0d_miss", i), 32'(ras_miss), 32'h0);
      step($sformatf("ret%0d", i), ra[i]);
    end
    ret = 1; jr_target = 32'h900;
    #1 chk("ret_drop_miss", 32'(ras_miss), 32'h1);
    step("ret_drop", 32'h900);
    chk("ovf_sticky", 32'(ras_ovf), 32'h1);

    // Call together with return replaces the top entry.
    goto(32'h100);
    jump = 1; call = 1; jump_idx = 26'h80;
    step("jal_200", 32'h200);
    jr = 1; call = 1; ret = 1; jr_target = 32'h300;
    step("call_ret", 32'h104);
    ret = 1;
    step("ret_replaced", 32'h204);
    ret = 1; jr_target = 32'h500;
    #1 chk("ret_after_replace_miss", 32'(ras_miss), 32'h1);
    step("ret_after_replace", 32'h500);

    // Stall holds; exception overrides stall; eret restores.
    goto(32'h40);
    stall = 1; jump = 1; jump_idx = 26'h3;
    #1 chk("stall_pc_nxt", pc_nxt, 32'h40);
    step("stall_hold", 32'h40);
    exception = 1; stall = 1; jump = 1; jump_idx = 26'h3;
    step("exception", 32'h80);
    chk("epc", epc, 32'h40);
    eret = 1;
    step("eret", 32'h40);

    // Address wrap and misaligned register jump.
    goto(32'hFFFF_FFFC);
    step("wrap", 32'h0);
    jr = 1; jr_target = 32'h103;
    #1 chk("misaligned_set", 32'(misaligned), 32'h1);
    step("jr_misaligned", 32'h100);
    jr_target = 32'h104;
    #1 chk("misaligned_clr", 32'(misaligned), 32'h0);

    // Reset mid-operation clears pc, epc, stack contents and overflow flag.
    jump = 1; call = 1; jump_idx = 26'h40;
    step("jal_pre_rst", 32'h100);
    reset = 0;
    #1;
    chk("mid_rst_pc", pc, 32'h0);
    chk("mid_rst_epc", epc, 32'h0);
    chk("mid_rst_ovf", 32'(ras_ovf), 32'h0);
    @(negedge clk);
    reset = 1;
    ret = 1; jr_target = 32'h60;
    #1 chk("post_rst_miss", 32'(ras_miss), 32'h1);
    step("post_rst_ret", 32'h60);

    @(negedge clk);
    chk("sb_drain", 32'(exp_q.size()), 32'h0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
